// File: rtl/memory_cycle_if.sv
// Data-memory request/grant/response bus between the MEM stage and data memory.
// The MEM stage is the master; the memory (or its arbiter) is the slave.
interface memory_cycle_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: issues data-memory requests, aligns store
// lanes, extracts and extends load data, stalls while an access is in flight,
// and holds the MEM/WB register that feeds writeback.
module memory_cycle (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_M,
  input  logic [31:0]           alu_result_M,
  input  logic [31:0]           store_data_M,
  input  logic [4:0]            rd_addr_M,
  input  logic                  rd_wren_M,
  input  logic                  mem_load_M,
  input  logic                  mem_store_M,
  input  logic [2:0]            funct3_M,
  output logic                  stall_M,
  output logic                  misaligned_o,
  memory_cycle_if.master        dmem,
  output logic                  wb_valid_o,
  output logic [31:0]           wb_result_o,
  output logic [31:0]           wb_ld_data_o,
  output logic [4:0]            wb_rd_addr_o,
  output logic                  wb_rd_wren_o,
  output logic                  wb_mem_load_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_e;

  state_e      state_q;

  // Request fields captured at issue; held on the bus while waiting for grant
  // and used for lane selection when the read data returns.
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        gnt;
  logic        complete;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [1:0]  sel_off;
  logic [2:0]  sel_funct3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign mem_op       = valid_M & (mem_load_M | mem_store_M);
  assign issue        = (state_q == IDLE) & mem_op & ~misaligned;
  assign misaligned_o = (state_q == IDLE) & mem_op & misaligned;
  assign gnt          = dmem.dmem_gnt_i & dmem.dmem_req_o;

  // Decode access legality and the byte-lane pattern of the incoming access.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    misaligned = 1'b0;
    be_c       = 4'h0;
    wdata_c    = store_data_M;
    off        = alu_result_M[1:0];
    case (funct3_M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{store_data_M[7:0]}};
      end
      2'b01: begin
        be_c       = 4'b0011 << off;
        wdata_c    = {2{store_data_M[15:0]}};
        misaligned = off[0];
      end
      2'b10: begin
        be_c       = 4'hF;
        misaligned = |off;
      end
      default: misaligned = 1'b1;
    endcase
    // Loads accept only B/H/W/BU/HU; stores only B/H/W.
    if (mem_load_M && funct3_M[2] && funct3_M[1]) misaligned = 1'b1;
    if (mem_store_M && funct3_M[2]) misaligned = 1'b1;
  end

  // Drive the bus from live inputs in IDLE and from the held copy afterwards.
  always_comb begin
    dmem.dmem_req_o   = 1'b0;
    dmem.dmem_we_o    = we_q;
    dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
    dmem.dmem_be_o    = be_q;
    dmem.dmem_wdata_o = wdata_q;
    case (state_q)
      IDLE: begin
        dmem.dmem_req_o   = issue;
        dmem.dmem_we_o    = mem_store_M;
        dmem.dmem_addr_o  = {alu_result_M[31:2], 2'b00};
        dmem.dmem_be_o    = be_c;
        dmem.dmem_wdata_o = wdata_c;
      end
      WAIT_GNT: dmem.dmem_req_o = 1'b1;
      default:  dmem.dmem_req_o = 1'b0;
    endcase
  end

  // Decide whether the access in flight finishes this cycle; stall otherwise.
  always_comb begin
    complete = 1'b0;
    case (state_q)
      IDLE:        complete = issue & gnt & (mem_store_M | dmem.dmem_rvalid_i);
      WAIT_GNT:    complete = gnt & (we_q | dmem.dmem_rvalid_i);
      WAIT_RVALID: complete = dmem.dmem_rvalid_i;
      default:     complete = 1'b0;
    endcase
    stall_M = (issue | (state_q != IDLE)) & ~complete;
  end

  // Pick the addressed byte/halfword of the returned word and extend it.
  always_comb begin
    sel_off    = (state_q == IDLE) ? alu_result_M[1:0] : addr_q[1:0];
    sel_funct3 = (state_q == IDLE) ? funct3_M : funct3_q;
    ld_byte    = dmem.dmem_rdata_i[{sel_off, 3'b000} +: 8];
    ld_half    = dmem.dmem_rdata_i[{sel_off[1], 4'b0000} +: 16];
    case (sel_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem.dmem_rdata_i;
    endcase
  end

  // Access sequencer: IDLE -> (WAIT_GNT) -> (WAIT_RVALID) -> IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every flop, including the held request fields, is cleared by the async reset so an abort leaves no stale bus drive.
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (issue) begin
        addr_q   <= alu_result_M;
        we_q     <= mem_store_M;
        be_q     <= be_c;
        wdata_q  <= wdata_c;
        funct3_q <= funct3_M;
      end
      case (state_q)
        IDLE:        if (issue && !complete) state_q <= gnt ? WAIT_RVALID : WAIT_GNT;
        WAIT_GNT:    if (gnt) state_q <= complete ? IDLE : WAIT_RVALID;
        WAIT_RVALID: if (dmem.dmem_rvalid_i) state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  // MEM/WB register: a finished instruction or a bubble every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_result_o   <= '0;
      wb_ld_data_o  <= '0;
      wb_rd_addr_o  <= '0;
      wb_rd_wren_o  <= 1'b0;
      wb_mem_load_o <= 1'b0;
    end else if (complete || (state_q == IDLE && valid_M && !mem_op)) begin
      wb_valid_o    <= 1'b1;
      wb_result_o   <= alu_result_M;
      wb_ld_data_o  <= mem_load_M ? ld_ext : 32'h0;
      wb_rd_addr_o  <= rd_addr_M;
      wb_rd_wren_o  <= rd_wren_M;
      wb_mem_load_o <= mem_load_M;
    end else begin
      wb_valid_o    <= 1'b0;
      wb_result_o   <= '0;
      wb_ld_data_o  <= '0;
      wb_rd_addr_o  <= '0;
      wb_rd_wren_o  <= 1'b0;
      wb_mem_load_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed cases plus randomized traffic
// against a byte-addressed reference memory, with scoreboard queues for both
// bus requests and MEM/WB results.
module tb_memory_cycle;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] ld_data;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_load;
  } wb_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_M = 1'b0;
  logic [31:0] alu_result_M = '0;
  logic [31:0] store_data_M = '0;
  logic [4:0]  rd_addr_M = '0;
  logic        rd_wren_M = 1'b0;
  logic        mem_load_M = 1'b0;
  logic        mem_store_M = 1'b0;
  logic [2:0]  funct3_M = '0;
  logic        stall_M;
  logic        misaligned_o;
  logic        wb_valid_o;
  logic [31:0] wb_result_o;
  logic [31:0] wb_ld_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_rd_wren_o;
  logic        wb_mem_load_o;

  memory_cycle_if dmem_if ();

  memory_cycle dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_M       (valid_M),
    .alu_result_M  (alu_result_M),
    .store_data_M  (store_data_M),
    .rd_addr_M     (rd_addr_M),
    .rd_wren_M     (rd_wren_M),
    .mem_load_M    (mem_load_M),
    .mem_store_M   (mem_store_M),
    .funct3_M      (funct3_M),
    .stall_M       (stall_M),
    .misaligned_o  (misaligned_o),
    .dmem          (dmem_if),
    .wb_valid_o    (wb_valid_o),
    .wb_result_o   (wb_result_o),
    .wb_ld_data_o  (wb_ld_data_o),
    .wb_rd_addr_o  (wb_rd_addr_o),
    .wb_rd_wren_o  (wb_rd_wren_o),
    .wb_mem_load_o (wb_mem_load_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  req_t req_q[$];
  wb_t  wb_q[$];

  // Memory as seen by the responder (word array) and by the reference model (bytes).
  logic [31:0] ram [0:255];
  logic [7:0]  ref_bytes [0:1023];

  int          gnt_delay = 0;
  int          rv_delay  = 0;
  int          gcnt = 0;
  int          rcnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rword = '0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    ram[a >> 2] = v;
    for (int i = 0; i < 4; i++) ref_bytes[(a & ~3) + i] = 8'(v >> (8 * i));
  endtask

  function automatic bit is_bad(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  // Present one instruction, model its effects, hold it while stalled, and end
  // on the negedge after it leaves MEM.
  task automatic run_instr(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input bit wren, output int stalls);
    bit     mop, mis, exp_wb;
    int     sz, a;
    longint val;
    req_t   r;
    wb_t    e;
    valid_M = v; mem_load_M = ld; mem_store_M = st; funct3_M = f3;
    alu_result_M = addr; store_data_M = data; rd_addr_M = rd; rd_wren_M = wren;
    mop    = v && (ld || st);
    mis    = mop && is_bad(ld, st, f3, addr);
    exp_wb = v && !mis;
    val    = 0;
    if (mop && !mis) begin
      sz      = 1 << f3[1:0];
      a       = int'(addr[9:0]);
      r.addr  = {addr[31:2], 2'b00};
      r.we    = st;
      r.be    = 4'(((1 << sz) - 1) << addr[1:0]);
      r.wdata = (sz == 1) ? 32'(data[7:0]) * 32'h0101_0101 :
                (sz == 2) ? 32'(data[15:0]) * 32'h0001_0001 : data;
      req_q.push_back(r);
      if (st) begin
        for (int i = 0; i < sz; i++) ref_bytes[a + i] = 8'(data >> (8 * i));
      end else begin
        for (int i = 0; i < sz; i++) val += longint'(ref_bytes[a + i]) << (8 * i);
        if (!f3[2] && sz < 4 && val >= (longint'(1) << (8 * sz - 1))) val -= longint'(1) << (8 * sz);
      end
    end
    if (exp_wb) begin
      e.result   = addr;
      e.ld_data  = (mop && ld) ? 32'(val) : 32'h0;
      e.rd_addr  = rd;
      e.rd_wren  = wren;
      e.mem_load = mop && ld;
      wb_q.push_back(e);
    end
    #2;
    check("misaligned_o", misaligned_o, mis);
    if (mis) check("no_req_on_misaligned", dmem_if.dmem_req_o, 1'b0);
    stalls = 0;
    while (stall_M && stalls < 200) begin
      @(negedge clk_i); #2;
      stalls++;
    end
    if (stalls >= 200) check("stall_timeout", stall_M, 1'b0);
    @(negedge clk_i);
    check("wb_valid_latency", wb_valid_o, exp_wb);
    valid_M = 1'b0; mem_load_M = 1'b0; mem_store_M = 1'b0;
  endtask

  // Memory responder: grant after gnt_delay cycles, return read data rv_delay cycles after grant.
  initial begin : responder
    req_t r;
    forever begin
      @(negedge clk_i); #1;
      dmem_if.dmem_gnt_i    = 1'b0;
      dmem_if.dmem_rvalid_i = 1'b0;
      dmem_if.dmem_rdata_i  = $urandom();
      if (rv_pend) begin
        if (rcnt == 0) begin
          dmem_if.dmem_rvalid_i = 1'b1;
          dmem_if.dmem_rdata_i  = rword;
          rv_pend = 1'b0;
        end else rcnt--;
      end else if (dmem_if.dmem_req_o) begin
        if (gcnt < gnt_delay) gcnt++;
        else begin
          gcnt = 0;
          dmem_if.dmem_gnt_i = 1'b1;
          last_addr  = dmem_if.dmem_addr_o;
          last_be    = dmem_if.dmem_be_o;
          last_wdata = dmem_if.dmem_wdata_o;
          if (req_q.size() == 0) check("unexpected_req", dmem_if.dmem_req_o, 1'b0);
          else begin
            r = req_q.pop_front();
            check("req_addr_we_be", {dmem_if.dmem_addr_o, dmem_if.dmem_we_o, dmem_if.dmem_be_o},
                  {r.addr, r.we, r.be});
            if (r.we) check("req_wdata", dmem_if.dmem_wdata_o, r.wdata);
          end
          if (dmem_if.dmem_we_o) begin
            for (int i = 0; i < 4; i++)
              if (dmem_if.dmem_be_o[i]) ram[dmem_if.dmem_addr_o[9:2]][8 * i +: 8] = dmem_if.dmem_wdata_o[8 * i +: 8];
          end else begin
            rword = ram[dmem_if.dmem_addr_o[9:2]];
            if (rv_delay == 0) begin
              dmem_if.dmem_rvalid_i = 1'b1;
              dmem_if.dmem_rdata_i  = rword;
            end else begin
              rv_pend = 1'b1;
              rcnt    = rv_delay - 1;
            end
          end
        end
      end else gcnt = 0;
    end
  end

  // Writeback monitor: every valid MEM/WB entry must match the next expected result.
  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (wb_valid_o) begin
          if (wb_q.size() == 0) check("unexpected_wb_valid", wb_valid_o, 1'b0);
          else begin
            e = wb_q.pop_front();
            check("wb_fields", {wb_result_o, wb_ld_data_o, wb_rd_addr_o, wb_rd_wren_o, wb_mem_load_o}, e);
          end
        end else check("bubble_wren", wb_rd_wren_o, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int st, wb_seen, kind;
    bit ld, sto, v;
    logic [2:0]  f3;
    logic [31:0] addr;
    dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0; dmem_if.dmem_rdata_i = '0;
    for (int i = 0; i < 256; i++) set_word(i * 4, $urandom());

    // Reset state
    #12;
    check("rst_req", dmem_if.dmem_req_o, 1'b0);
    check("rst_wb", {wb_valid_o, wb_result_o, wb_ld_data_o, wb_rd_addr_o, wb_rd_wren_o, wb_mem_load_o}, '0);
    check("rst_stall", stall_M, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Non-memory instruction
    run_instr(1, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, st);
    check("nonmem_stalls", st, 0);
    check("nonmem_wb", {wb_result_o, wb_rd_addr_o, wb_mem_load_o}, {32'h1234, 5'd5, 1'b0});

    // SB with immediate grant
    gnt_delay = 0; rv_delay = 0;
    run_instr(1, 0, 1, 3'd0, 32'h103, 32'hAABBCCDD, 5'd0, 0, st);
    check("sb_stalls", st, 0);
    check("sb_bus", {last_addr, last_be, last_wdata}, {32'h100, 4'b1000, 32'hDDDDDDDD});
    check("sb_wren", wb_rd_wren_o, 1'b0);

    // LB / LBU with delayed grant and delayed rvalid
    set_word(32'h100, 32'h12F45678);
    gnt_delay = 2; rv_delay = 3;
    run_instr(1, 1, 0, 3'd0, 32'h102, 32'h0, 5'd7, 1, st);
    check("lb_stalls", st, 5);
    check("lb_data", {wb_ld_data_o, wb_mem_load_o}, {32'hFFFFFFF4, 1'b1});
    run_instr(1, 1, 0, 3'd4, 32'h102, 32'h0, 5'd8, 1, st);
    check("lbu_stalls", st, 5);
    check("lbu_data", wb_ld_data_o, 32'h000000F4);

    // Misaligned LH
    run_instr(1, 1, 0, 3'd1, 32'h201, 32'h0, 5'd9, 1, st);
    check("lh_mis_stalls", st, 0);

    // LW with grant and rvalid in the same cycle
    set_word(32'h300, 32'hCAFEBABE);
    gnt_delay = 0; rv_delay = 0;
    run_instr(1, 1, 0, 3'd2, 32'h300, 32'h0, 5'd10, 1, st);
    check("lw_stalls", st, 0);
    check("lw_data", wb_ld_data_o, 32'hCAFEBABE);

    // Reset while waiting for rvalid; the stale rvalid must not retire anything
    gnt_delay = 0; rv_delay = 6;
    valid_M = 1; mem_load_M = 1; mem_store_M = 0; funct3_M = 3'd2;
    alu_result_M = 32'h304; rd_addr_M = 5'd11; rd_wren_M = 1;
    req_q.push_back('{addr: 32'h304, we: 1'b0, be: 4'hF, wdata: 32'h0});
    @(negedge clk_i); #2;
    check("abort_stall_before", stall_M, 1'b1);
    @(negedge clk_i); #3;
    rst_ni = 1'b0; valid_M = 1'b0; mem_load_M = 1'b0;
    #1;
    check("abort_req", dmem_if.dmem_req_o, 1'b0);
    check("abort_wb", {wb_valid_o, wb_result_o, wb_ld_data_o, wb_rd_addr_o, wb_rd_wren_o, wb_mem_load_o}, '0);
    check("abort_stall", stall_M, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wb_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (wb_valid_o) wb_seen++;
    end
    check("stale_rvalid_ignored", wb_seen, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(0, 3);
      v = 1; ld = 0; sto = 0; f3 = 3'($urandom_range(0, 7)); addr = $urandom();
      if (kind < 2) begin
        v = 1;
      end else if (kind == 2) begin
        v = 0; ld = $urandom_range(0, 1); sto = !ld;
      end else begin
        ld = $urandom_range(0, 1); sto = !ld;
        if ($urandom_range(0, 7) != 0) begin
          if (ld) begin
            case ($urandom_range(0, 4))
              0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
          end else f3 = 3'($urandom_range(0, 2));
        end
        addr = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      end
      run_instr(v, ld, sto, f3, addr, $urandom(), 5'($urandom()), sto ? 1'b0 : 1'($urandom()), st);
    end

    repeat (4) @(negedge clk_i);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the 5-stage RV32I pipeline; sits directly upstream of the writeback stage.
- Drives the data-memory request/grant/response interface. Performs byte-lane alignment for stores and extraction plus sign/zero extension for loads.
- Stalls the pipeline while a memory access is outstanding. Holds the MEM/WB pipeline register that feeds writeback (ALU result, load data, rd address/write-enable, load-select).

Parameters:
- none (RV32 fixed: 32-bit data, 5-bit register addresses)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- valid_M  in  1  instruction present in MEM
- alu_result_M  in  32  ALU result / effective address
- store_data_M  in  32  rs2 value for stores
- rd_addr_M  in  5  destination register
- rd_wren_M  in  1  destination write-enable
- mem_load_M  in  1  instruction is a load
- mem_store_M  in  1  instruction is a store
- funct3_M  in  3  access size/sign (RV32I encoding)
- stall_M  out  1  hold IF..MEM (combinational)
- misaligned_o  out  1  one-cycle pulse: misaligned or illegal-size access dropped
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word
- wb_valid_o  out  1  MEM/WB register holds a real instruction
- wb_result_o  out  32  registered ALU result
- wb_ld_data_o  out  32  registered extended load data
- wb_rd_addr_o  out  5  registered rd
- wb_rd_wren_o  out  1  registered write-enable; 0 for bubbles
- wb_mem_load_o  out  1  registered load-select

Behaviour:
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID. Reset: IDLE; every registered output 0; dmem_req_o = 0.
- mem_op = valid_M & (mem_load_M | mem_store_M).
- Misaligned/illegal access:
  - misaligned = halfword with addr[0]=1; word with addr[1:0]≠0; load funct3 ∈ {011,110,111}; store funct3 > 010.
  - No request is issued. misaligned_o pulses. MEM/WB captures a bubble (wb_valid_o=0, wb_rd_wren_o=0). No stall.
- Request issue:
  - IDLE with aligned mem_op: dmem_req_o=1 combinationally, with addr/be/wdata/we derived from the current inputs.
  - Store be/wdata: SB: be=1<<addr[1:0], byte replicated ×4. SH: be=3<<addr[1:0], halfword replicated ×2. SW: be=4'hF.
  - Load: be as above; dmem_we_o=0.
- Grant in IDLE:
  - Store completes in the same cycle.
  - Load moves to WAIT_RVALID.
- No grant in IDLE: move to WAIT_GNT. Request fields are registered and held stable with dmem_req_o=1 until gnt. Then: store → IDLE (complete); load → WAIT_RVALID.
- WAIT_RVALID: dmem_req_o=0. On dmem_rvalid_i → complete → IDLE.
  - rvalid arriving in the same cycle as gnt (from IDLE or WAIT_GNT) completes the load immediately.
  - rvalid_i in IDLE/WAIT_GNT with no load outstanding is ignored.
- Load extraction:
  - Select byte/halfword by the registered addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- stall_M = mem_op_active & ~complete_this_cycle.
- MEM/WB register updates every cycle:
  - Completing mem op or valid non-mem instruction: capture wb_valid=1, result=alu_result, rd fields, wb_mem_load=mem_load, ld_data=extended data (0 for non-loads).
  - While stall_M=1: capture a bubble, so writeback never sees a partial op.
  - Invalid/misaligned: bubble.
- Latency:
  - Non-mem: 1 cycle to wb_*.
  - Mem op with gnt in cycle N and rvalid in cycle N+k: wb_* valid at edge N+k+1.
- Asynchronous reset mid-operation: immediately IDLE, outputs 0, dmem_req_o deasserted. A later stale rvalid_i is ignored.

Test Plan:
- Non-mem: valid_M=1, alu_result=0x1234, rd=5, wren=1 → next cycle wb_valid=1, wb_result=0x1234, wb_rd_addr=5, wb_mem_load=0, stall_M=0.
- SB addr=0x103, data=0xAABBCCDD, gnt same cycle → dmem_be=4'b1000, dmem_wdata=0xDDDDDDDD, addr=0x100, stall_M=0, wb_rd_wren=0.
- LB addr=0x102, gnt delayed 2 cycles, rvalid 3 cycles later, rdata=0x12F45678 → stall_M high 5 cycles; wb_ld_data=0xFFFFFFF4, wb_mem_load=1. LBU same → 0x000000F4.
- LH addr=0x201 → no dmem_req_o, misaligned_o=1 for one cycle, wb_valid=0, stall_M=0.
- LW with gnt and rvalid in same cycle, rdata=0xCAFEBABE → no stall; wb_ld_data=0xCAFEBABE next edge.
- rst_ni low while in WAIT_RVALID → dmem_req_o=0 and all wb_*=0 immediately; state IDLE; later rvalid pulse produces no wb_valid.
